// File: rtl/z_core_wb_arbiter.sv
// Writeback arbiter: round-robin merge of ALU and LSU results into one registered
// register-file write port, with staged-write hazard flags and a saturating stall counter.
module z_core_wb_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [4:0]       lsu_rd,
  input  logic [31:0]      lsu_data,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [31:0]      rf_rd_in,
  input  logic [4:0]       rs1_q,
  input  logic [4:0]       rs2_q,
  output logic             hazard_rs1,
  output logic             hazard_rs2,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  src_e             last_q, last_d;
  logic             stg_valid_q, stg_valid_d;
  logic [4:0]       stg_rd_q, stg_rd_d;
  logic [31:0]      stg_data_q, stg_data_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             alu_xfer, lsu_xfer, stall_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= SRC_LSU;
      stg_valid_q <= 1'b0;
      stg_rd_q    <= 5'd0;
      stg_data_q  <= 32'd0;
      stall_q     <= '0;
    end else begin
      last_q      <= last_d;
      stg_valid_q <= stg_valid_d;
      stg_rd_q    <= stg_rd_d;
      stg_data_q  <= stg_data_d;
      stall_q     <= stall_d;
    end
  end

  // Ready depends only on the other source and the pointer, so at most one
  // side can transfer per cycle; the one not granted last wins a conflict.
  always_comb begin
    alu_ready   = !(lsu_valid && last_q == SRC_ALU);
    lsu_ready   = !(alu_valid && last_q == SRC_LSU);
    alu_xfer    = alu_valid && alu_ready;
    lsu_xfer    = lsu_valid && lsu_ready;
    stall_inc   = (alu_valid && !alu_ready) || (lsu_valid && !lsu_ready);
    last_d      = last_q;
    stg_valid_d = 1'b0;
    stg_rd_d    = stg_rd_q;
    stg_data_d  = stg_data_q;
    stall_d     = stall_q;
    if (alu_xfer) begin
      last_d      = SRC_ALU;
      stg_valid_d = (alu_rd != 5'd0);
      stg_rd_d    = alu_rd;
      stg_data_d  = alu_data;
    end else if (lsu_xfer) begin
      last_d      = SRC_LSU;
      stg_valid_d = (lsu_rd != 5'd0);
      stg_rd_d    = lsu_rd;
      stg_data_d  = lsu_data;
    end
    if (stall_inc && stall_q != {CNT_W{1'b1}}) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_comb begin
    rf_we      = stg_valid_q;
    rf_rd      = stg_rd_q;
    rf_rd_in   = stg_data_q;
    hazard_rs1 = stg_valid_q && (stg_rd_q == rs1_q) && (rs1_q != 5'd0);
    hazard_rs2 = stg_valid_q && (stg_rd_q == rs2_q) && (rs2_q != 5'd0);
    stall_cnt  = stall_q;
  end

endmodule
